// File: rtl/munoc_inter_router_fifo_synch_if.sv
// Link bundle between two routers: forward and backward phit links,
// their readies and the occupancy/idle status of the FIFO pair.
`ifndef BW_FNI_LINK
`define BW_FNI_LINK(BW) ((BW)+1)
`endif
`ifndef BW_BNI_LINK
`define BW_BNI_LINK(BW) ((BW)+1)
`endif

interface munoc_inter_router_fifo_synch_if #(
   parameter int BW_FNI_PHIT = 8,
   parameter int BW_BNI_PHIT = 8,
   parameter int NUM_BUFFER  = 2
);
   localparam int LW_F   = `BW_FNI_LINK(BW_FNI_PHIT);
   localparam int LW_B   = `BW_BNI_LINK(BW_BNI_PHIT);
   localparam int BW_CNT = $clog2(NUM_BUFFER + 1);

   logic [LW_F-1:0]   rfni_link;
   logic              rfni_ready;
   logic [LW_B-1:0]   rbni_link;
   logic              rbni_ready;
   logic [LW_F-1:0]   sfni_link;
   logic              sfni_ready;
   logic [LW_B-1:0]   sbni_link;
   logic              sbni_ready;
   logic [BW_CNT-1:0] fni_count;
   logic [BW_CNT-1:0] bni_count;
   logic              idle;

   modport slave (
      input  rfni_link,
      output rfni_ready,
      output rbni_link,
      input  rbni_ready,
      output sfni_link,
      input  sfni_ready,
      input  sbni_link,
      output sbni_ready,
      output fni_count,
      output bni_count,
      output idle
   );

   modport master (
      output rfni_link,
      input  rfni_ready,
      input  rbni_link,
      output rbni_ready,
      input  sfni_link,
      output sfni_ready,
      output sbni_link,
      input  sbni_ready,
      input  fni_count,
      input  bni_count,
      input  idle
   );
endinterface

// File: rtl/munoc_inter_router_fifo_synch.sv
// Inter-router FIFO pair: forward (rfni->sfni) and backward (sbni->rbni),
// each a registered circular buffer with state-only valid/ready.
`ifndef BW_FNI_LINK
`define BW_FNI_LINK(BW) ((BW)+1)
`endif
`ifndef BW_BNI_LINK
`define BW_BNI_LINK(BW) ((BW)+1)
`endif

module munoc_inter_router_fifo_synch_chan #(
   parameter int LW     = 9,
   parameter int DEPTH  = 2,
   parameter int BW_CNT = 2
) (
   input  logic              clk,
   input  logic              rstnn,
   input  logic [LW-1:0]     wr_link,
   output logic              wr_ready,
   output logic [LW-1:0]     rd_link,
   input  logic              rd_ready,
   output logic [BW_CNT-1:0] count
);
   localparam int BW_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [BW_PTR-1:0] PTR_LAST = BW_PTR'(DEPTH - 1);
   localparam logic [BW_CNT-1:0] CNT_FULL = BW_CNT'(DEPTH);

   logic [LW-2:0]     mem_q [DEPTH];
   logic [LW-2:0]     mem_d [DEPTH];
   logic [BW_PTR-1:0] wptr_q, wptr_d;
   logic [BW_PTR-1:0] rptr_q, rptr_d;
   logic [BW_CNT-1:0] count_q, count_d;
   logic              not_empty;
   logic              push;
   logic              pop;

   // Readiness and valid come only from count_q, never from the inputs.
   assign not_empty = (count_q != '0);
   assign wr_ready  = (count_q < CNT_FULL);
   assign push      = wr_link[LW-1] & wr_ready;
   assign pop       = not_empty & rd_ready;
   assign count     = count_q;
   assign rd_link   = not_empty ? {1'b1, mem_q[rptr_q]} : '0;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[wptr_q] = wr_link[LW-2:0];
         wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + BW_PTR'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + BW_PTR'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + BW_CNT'(1);
         2'b01:   count_d = count_q - BW_CNT'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Payload storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

module munoc_inter_router_fifo_synch #(
   parameter int BW_FNI_PHIT = 8,
   parameter int BW_BNI_PHIT = 8,
   parameter int NUM_BUFFER  = 2
) (
   input  logic clk,
   input  logic rstnn,
   munoc_inter_router_fifo_synch_if.slave port
);
   localparam int LW_F   = `BW_FNI_LINK(BW_FNI_PHIT);
   localparam int LW_B   = `BW_BNI_LINK(BW_BNI_PHIT);
   localparam int BW_CNT = $clog2(NUM_BUFFER + 1);

   logic [BW_CNT-1:0] fni_cnt;
   logic [BW_CNT-1:0] bni_cnt;

   munoc_inter_router_fifo_synch_chan #(
      .LW     (LW_F),
      .DEPTH  (NUM_BUFFER),
      .BW_CNT (BW_CNT)
   ) u_fwd (
      .clk      (clk),
      .rstnn    (rstnn),
      .wr_link  (port.rfni_link),
      .wr_ready (port.rfni_ready),
      .rd_link  (port.sfni_link),
      .rd_ready (port.sfni_ready),
      .count    (fni_cnt)
   );

   munoc_inter_router_fifo_synch_chan #(
      .LW     (LW_B),
      .DEPTH  (NUM_BUFFER),
      .BW_CNT (BW_CNT)
   ) u_bwd (
      .clk      (clk),
      .rstnn    (rstnn),
      .wr_link  (port.sbni_link),
      .wr_ready (port.sbni_ready),
      .rd_link  (port.rbni_link),
      .rd_ready (port.rbni_ready),
      .count    (bni_cnt)
   );

   assign port.fni_count = fni_cnt;
   assign port.bni_count = bni_cnt;
   assign port.idle      = (fni_cnt == '0) && (bni_cnt == '0);
endmodule

// File: tb/tb_munoc_inter_router_fifo_synch.sv
// Directed bench for the inter-router FIFO pair (depth 2 and depth 3),
// plus a short random bidirectional phase checked against queues.
module tb_munoc_inter_router_fifo_synch;
   logic clk;
   logic rstnn;
   int   n_cmp;
   int   n_err;

   logic [7:0] fq[$];
   logic [7:0] bq[$];

   munoc_inter_router_fifo_synch_if #(.NUM_BUFFER(2)) f2 ();
   munoc_inter_router_fifo_synch_if #(.NUM_BUFFER(3)) f3 ();

   munoc_inter_router_fifo_synch #(
      .BW_FNI_PHIT (8),
      .BW_BNI_PHIT (8),
      .NUM_BUFFER  (2)
   ) dut2 (
      .clk   (clk),
      .rstnn (rstnn),
      .port  (f2)
   );

   munoc_inter_router_fifo_synch #(
      .BW_FNI_PHIT (8),
      .BW_BNI_PHIT (8),
      .NUM_BUFFER  (3)
   ) dut3 (
      .clk   (clk),
      .rstnn (rstnn),
      .port  (f3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [8:0] exp_l;
      n_cmp = 0;
      n_err = 0;
      rstnn = 1'b0;
      f2.rfni_link = '0; f2.sfni_ready = 1'b0;
      f2.sbni_link = '0; f2.rbni_ready = 1'b0;
      f3.rfni_link = '0; f3.sfni_ready = 1'b0;
      f3.sbni_link = '0; f3.rbni_ready = 1'b0;
      step();
      step();

      // reset state
      chk("rst_fcnt", 32'(f2.fni_count), 0);
      chk("rst_bcnt", 32'(f2.bni_count), 0);
      chk("rst_frdy", 32'(f2.rfni_ready), 1);
      chk("rst_brdy", 32'(f2.sbni_ready), 1);
      chk("rst_slink", 32'(f2.sfni_link), 0);
      chk("rst_rlink", 32'(f2.rbni_link), 0);
      chk("rst_idle", 32'(f2.idle), 1);
      rstnn = 1'b1;
      step();

      // single phit
      f2.rfni_link = 9'h1A5;
      step();
      f2.rfni_link = '0;
      chk("one_link", 32'(f2.sfni_link), 32'h1A5);
      chk("one_cnt", 32'(f2.fni_count), 1);
      chk("one_idle", 32'(f2.idle), 0);
      f2.sfni_ready = 1'b1;
      step();
      chk("one_cnt0", 32'(f2.fni_count), 0);
      chk("one_idle1", 32'(f2.idle), 1);
      chk("one_link0", 32'(f2.sfni_link), 0);
      f2.sfni_ready = 1'b0;

      // fill and backpressure
      f2.rfni_link = 9'h111;
      step();
      chk("fill1_rdy", 32'(f2.rfni_ready), 1);
      f2.rfni_link = 9'h122;
      step();
      chk("fill2_rdy", 32'(f2.rfni_ready), 0);
      chk("fill2_cnt", 32'(f2.fni_count), 2);
      f2.rfni_link = 9'h133;
      step();
      chk("fill3_cnt", 32'(f2.fni_count), 2);
      chk("fill3_link", 32'(f2.sfni_link), 32'h111);

      // full with simultaneous pop
      f2.rfni_link = 9'h144;
      f2.sfni_ready = 1'b1;
      step();
      chk("fp_cnt", 32'(f2.fni_count), 1);
      chk("fp_rdy", 32'(f2.rfni_ready), 1);
      chk("fp_link", 32'(f2.sfni_link), 32'h122);
      f2.sfni_ready = 1'b0;
      step();
      chk("fp_acc_cnt", 32'(f2.fni_count), 2);
      chk("fp_acc_link", 32'(f2.sfni_link), 32'h122);
      f2.rfni_link = '0;
      f2.sfni_ready = 1'b1;
      step();
      chk("fp_out44", 32'(f2.sfni_link), 32'h144);
      chk("fp_cnt1", 32'(f2.fni_count), 1);
      step();
      chk("fp_empty", 32'(f2.sfni_link), 0);
      chk("fp_idle", 32'(f2.idle), 1);
      f2.sfni_ready = 1'b0;

      // backward channel, forward stays untouched
      f2.sbni_link = 9'h1B1;
      step();
      f2.sbni_link = 9'h1B2;
      step();
      f2.sbni_link = '0;
      chk("bw_rdy", 32'(f2.sbni_ready), 0);
      chk("bw_cnt", 32'(f2.bni_count), 2);
      chk("bw_link", 32'(f2.rbni_link), 32'h1B1);
      chk("bw_fcnt", 32'(f2.fni_count), 0);
      f2.rbni_ready = 1'b1;
      step();
      chk("bw_link2", 32'(f2.rbni_link), 32'h1B2);
      chk("bw_cnt1", 32'(f2.bni_count), 1);
      step();
      chk("bw_cnt0", 32'(f2.bni_count), 0);
      chk("bw_link0", 32'(f2.rbni_link), 0);
      f2.rbni_ready = 1'b0;

      // wrap and streaming on depth 3
      f3.sfni_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         f3.rfni_link = {1'b1, 8'(k)};
         step();
         chk("str_link", 32'(f3.sfni_link), 32'({1'b1, 8'(k)}));
         chk("str_cnt", 32'(f3.fni_count), 1);
      end
      f3.rfni_link = '0;
      step();
      chk("str_end", 32'(f3.fni_count), 0);
      f3.sfni_ready = 1'b0;

      // random bidirectional traffic against queue scoreboards
      for (int c = 0; c < 300; c++) begin
         chk("rnd_fcnt", 32'(f2.fni_count), 32'(fq.size()));
         chk("rnd_bcnt", 32'(f2.bni_count), 32'(bq.size()));
         chk("rnd_ble2", 32'(f2.bni_count <= 2), 1);
         chk("rnd_frdy", 32'(f2.rfni_ready), 32'(fq.size() < 2));
         f2.rfni_link = ($urandom_range(0, 1) != 0) ?
                        {1'b1, 8'($urandom)} : '0;
         f2.sbni_link = ($urandom_range(0, 1) != 0) ?
                        {1'b1, 8'($urandom)} : '0;
         f2.sfni_ready = 1'($urandom_range(0, 1));
         f2.rbni_ready = 1'($urandom_range(0, 1));
         if (f2.sfni_link[8] && f2.sfni_ready) begin
            exp_l = (fq.size() > 0) ? {1'b1, fq[0]} : 9'h0;
            chk("rnd_fdata", 32'(f2.sfni_link), 32'(exp_l));
            if (fq.size() > 0) fq.delete(0);
         end
         if (f2.rbni_link[8] && f2.rbni_ready) begin
            exp_l = (bq.size() > 0) ? {1'b1, bq[0]} : 9'h0;
            chk("rnd_bdata", 32'(f2.rbni_link), 32'(exp_l));
            if (bq.size() > 0) bq.delete(0);
         end
         if (f2.rfni_link[8] && f2.rfni_ready)
            fq.push_back(f2.rfni_link[7:0]);
         if (f2.sbni_link[8] && f2.sbni_ready)
            bq.push_back(f2.sbni_link[7:0]);
         step();
      end
      f2.rfni_link = '0;
      f2.sbni_link = '0;
      f2.sfni_ready = 1'b1;
      f2.rbni_ready = 1'b1;
      step();
      step();
      step();
      chk("drain_idle", 32'(f2.idle), 1);
      fq.delete();
      bq.delete();
      f2.sfni_ready = 1'b0;
      f2.rbni_ready = 1'b0;

      // mid-operation reset
      f2.rfni_link = 9'h1C1;
      f2.sbni_link = 9'h1D1;
      step();
      f2.rfni_link = 9'h1C2;
      f2.sbni_link = '0;
      step();
      f2.rfni_link = '0;
      chk("mr_pre_cnt", 32'(f2.fni_count), 2);
      rstnn = 1'b0;
      #1;
      chk("mr_fcnt", 32'(f2.fni_count), 0);
      chk("mr_bcnt", 32'(f2.bni_count), 0);
      chk("mr_fval", 32'(f2.sfni_link[8]), 0);
      chk("mr_bval", 32'(f2.rbni_link[8]), 0);
      chk("mr_idle", 32'(f2.idle), 1);
      step();
      rstnn = 1'b1;
      f2.rfni_link = 9'h15A;
      step();
      f2.rfni_link = '0;
      chk("mr_head", 32'(f2.sfni_link), 32'h15A);
      chk("mr_cnt1", 32'(f2.fni_count), 1);
      f2.sfni_ready = 1'b1;
      step();
      chk("mr_cnt0", 32'(f2.fni_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
